mips_multicycle_cpu: RTL

Multicycle MIPS core that replaces the single-cycle datapath with an FSM sequencing one shared ALU and one unified instruction/data memory port. Memory may stall through a request/ready handshake. The core keeps the external three-port register-file interface. It sits between the top-level testbench memory model and the external register file.

---
 rtl/mips_multicycle_cpu_if.sv | 13 +
 rtl/mips_multicycle_cpu.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mips_multicycle_cpu_if.sv
// mips_multicycle_cpu_if: unified instruction/data memory request/ready bus
// master (core): mem_addr, mem_req, mem_we, mem_wdata out; mem_rdata, mem_ready in
// slave (memory): the mirror image
interface mips_multicycle_cpu_if;
   logic [31:0] mem_addr;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   modport master(output mem_addr, mem_req, mem_we, mem_wdata, input mem_rdata, mem_ready);
   modport slave(input mem_addr, mem_req, mem_we, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_multicycle_cpu.sv
// mips_multicycle_cpu: multicycle MIPS core, one shared ALU, one stallable memory port
// clk, reset        : clock, synchronous active-high reset
// mem (master)      : request/ready memory bus, PC in fetch, ALUOut in data access
// register_a1/a2/a3 : register file read/write indices
// register_we3/wd3  : register file write strobe and data
// register_rd1/rd2  : combinational register file read data
// retire            : pulses on the final cycle of each instruction
// MIPS_MC_JUMP_EN   : when defined, opcode 000010 (j) is decoded; otherwise it is a no-op
module mips_multicycle_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         reset,
   mips_multicycle_cpu_if.master        mem,
   output logic [4:0]                   register_a1,
   output logic [4:0]                   register_a2,
   output logic [4:0]                   register_a3,
   output logic                         register_we3,
   output logic [31:0]                  register_wd3,
   input  logic [31:0]                  register_rd1,
   input  logic [31:0]                  register_rd2,
   output logic                         retire
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH
`ifdef MIPS_MC_JUMP_EN
      , JUMP
`endif
   } state_t;
   state_t      state, dec_next;
   logic [31:0] pc, ir, mdr, a, b, aluout, imm, alu_a, alu_b, y;
   logic [5:0]  op, fn;
   logic [2:0]  alu_ctl, r_ctl;
   logic        is_r, is_lw, is_sw, is_beq, is_addi, wb, acc;
   assign op  = ir[31:26];
   assign fn  = ir[5:0];
   assign imm = {{16{ir[15]}}, ir[15:0]};
   always_comb begin
      r_ctl   = fn == 6'h22 ? 3'b110 : fn == 6'h24 ? 3'b000 : fn == 6'h25 ? 3'b001 : fn == 6'h2a ? 3'b111 : 3'b010;
      is_r    = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a);
      is_lw   = op == 6'h23;
      is_sw   = op == 6'h2b;
      is_beq  = op == 6'h04;
      is_addi = op == 6'h08;
      dec_next = is_lw || is_sw ? MEMADR : is_r ? EXEC : is_addi ? ADDIEX : is_beq ? BRANCH :
`ifdef MIPS_MC_JUMP_EN
                 op == 6'h02 ? JUMP :
`endif
                 FETCH;
   end
   // One ALU serves PC+4 in fetch, the branch target in decode and all execute work
   always_comb begin
      alu_a   = state == FETCH || state == DECODE ? pc : a;
      alu_b   = state == FETCH ? 32'd4 : state == DECODE ? {imm[29:0], 2'b00} :
                state == EXEC || state == BRANCH ? b : imm;
      alu_ctl = state == EXEC ? r_ctl : state == BRANCH ? 3'b110 : 3'b010;
      y = alu_ctl == 3'b110 ? alu_a - alu_b : alu_ctl == 3'b000 ? alu_a & alu_b :
          alu_ctl == 3'b001 ? alu_a | alu_b : alu_ctl == 3'b111 ? {31'b0, $signed(alu_a) < $signed(alu_b)} :
          alu_a + alu_b;
   end
   // Strobes are gated by reset so a reset landing on a stalled access issues nothing
   always_comb begin
      mem.mem_req   = ~reset && (state == FETCH || state == MEMRD || state == MEMWR);
      mem.mem_we    = ~reset && state == MEMWR;
      mem.mem_addr  = state == FETCH ? pc : aluout;
      mem.mem_wdata = b;
      acc           = mem.mem_req && mem.mem_ready;
      wb            = state == MEMWB || state == ALUWB || state == ADDIWB;
      register_a1   = ir[25:21];
      register_a2   = ir[20:16];
      register_a3   = op == 6'h00 ? ir[15:11] : ir[20:16];
      register_we3  = ~reset && wb && register_a3 != 5'd0;
      register_wd3  = state == MEMWB ? mdr : aluout;
      retire = ~reset && (wb || state == BRANCH ||
`ifdef MIPS_MC_JUMP_EN
               state == JUMP ||
`endif
               (state == DECODE && dec_next == FETCH) || (state == MEMWR && mem.mem_ready));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= FETCH;
         pc     <= RESET_PC;
         ir     <= '0;
         mdr    <= '0;
         a      <= '0;
         b      <= '0;
         aluout <= '0;
      end else begin
         case (state)
            FETCH: if (acc) begin
               ir    <= mem.mem_rdata;
               pc    <= y;
               state <= DECODE;
            end
            DECODE: begin
               a      <= register_rd1;
               b      <= register_rd2;
               aluout <= y;
               state  <= dec_next;
            end
            MEMADR: begin
               aluout <= y;
               state  <= is_lw ? MEMRD : MEMWR;
            end
            MEMRD: if (acc) begin
               mdr   <= mem.mem_rdata;
               state <= MEMWB;
            end
            MEMWR: if (acc) state <= FETCH;
            EXEC: begin
               aluout <= y;
               state  <= ALUWB;
            end
            ADDIEX: begin
               aluout <= y;
               state  <= ADDIWB;
            end
            BRANCH: begin
               if (y == 32'd0) pc <= aluout;
               state <= FETCH;
            end
`ifdef MIPS_MC_JUMP_EN
            JUMP: begin
               pc    <= {pc[31:28], ir[25:0], 2'b00};
               state <= FETCH;
            end
`endif
            default: state <= FETCH;
         endcase
      end
   end
endmodule
